normalizare_rezultat: RTL
=========================

Name: normalizare_rezultat

Overview:
- Post-add normalizer and packer for the single-precision ADD/SUB datapath; the counterpart of mantissa alignment.
- Alignment right-shifts the smaller operand before the adder. This block takes the raw signed-magnitude sum and produces a packed IEEE-754 word:
  - right-shift by one on carry-out, or left-shift one bit per cycle to remove leading zeros;
  - round-to-nearest-even using guard and sticky bits.
- Valid/ready on both sides.

Parameters:
- EXP_W, 8, exponent width
- FRAC_W, 23, stored fraction width (result width = 1+EXP_W+FRAC_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  sum word valid
- in_ready  out  1  block can accept (high only in IDLE)
- in_sign  in  1  result sign from adder
- in_exp  in  EXP_W  larger operand exponent
- in_mant  in  FRAC_W+3  {carry, hidden, fraction[FRAC_W-1:0], guard}
- in_sticky  in  1  OR of bits shifted out during alignment
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  1+EXP_W+FRAC_W  packed {sign, exp, frac}
- out_ovf  out  1  result overflowed to infinity
- out_zero  out  1  result is zero
- out_inexact  out  1  guard or sticky was set at rounding

Behaviour:
- Reset:
  - rst_n low at a clk edge forces state IDLE, out_valid=0, out_result=0, all flags=0.
  - in_ready is 1 from the first cycle after reset.
  - Reset wins over any handshake in the same cycle and aborts any operation in progress.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register sign, exp, mant, sticky, then go CHECK.
- CHECK (1 cycle), evaluated in priority order:
  - mant==0: result +0 (sign forced 0), out_zero=1, go DONE.
  - carry==1: mant>>=1; new guard=old frac LSB; sticky|=old guard; exp+=1.
    - If exp becomes all-ones: result {sign, all-ones, 0}, out_ovf=1, go DONE.
    - Else go ROUND.
  - hidden==1: go ROUND.
  - exp==0 (subnormal input): go ROUND, no shift.
  - Otherwise go SHIFT.
- SHIFT (1 bit per cycle):
  - mant<<=1, guard shifts into frac LSB, guard<=0, exp-=1.
  - Leave for ROUND when the shifted hidden bit is 1.
  - Leave for ROUND when exp reaches 1 with hidden still 0; then set exp=0 (subnormal result).
  - At most FRAC_W+1 cycles.
- ROUND (1 cycle):
  - out_inexact=guard|sticky.
  - Increment the {hidden, frac} field when guard&&(sticky||frac LSB).
  - Increment carry-out: frac=0, exp+=1. If exp becomes all-ones: infinity, out_ovf=1.
  - A subnormal rounding up into hidden gives exp=1.
  - Pack, go DONE.
- DONE:
  - out_valid=1; out_result and flags stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0, go IDLE.
  - in_ready=0 throughout DONE, so there is no same-cycle accept.
- Latency, counted from the accept edge to out_valid high:
  - zero or overflow-in-CHECK: 2 cycles;
  - normal: 3+k cycles, where k is the number of SHIFT cycles.
- Throughput: one operation in flight.
- Flags are cleared on each accept.

Optional Feature:
- Macro NORMALIZARE_FTZ_EN.
- Defined: any result that would pack with exp==0 and nonzero fraction is flushed to +0 with out_zero=1 and out_inexact=1. SHIFT still stops at exp==1.
- Undefined: subnormals are packed as computed (exp=0, fraction kept).

Test Plan:
1. 1.0+1.0: sign 0, exp=127, mant={1,0,23'h0,0}, sticky 0 -> out_result=0x40000000; out_valid 3 cycles after accept; flags 0.
2. Cancellation 1.0-0.5: exp=127, mant={0,0,23'h400000,0} -> one SHIFT -> 0x3F000000; out_valid 4 cycles after accept.
3. Exact zero: sign 1, mant=0 -> 0x00000000, out_zero=1, out_valid 2 cycles after accept.
4. Overflow: exp=254, mant={1,1,23'h0,0} -> 0x7F800000, out_ovf=1. Rounding overflow: exp=127, mant={0,1,23'h7FFFFF,1}, sticky 0 -> 0x40000000, out_inexact=1.
5. Subnormal: exp=1, mant={0,0,23'h000001,0} -> 0x00000001 without the macro; 0x00000000 with out_zero=1 when NORMALIZARE_FTZ_EN is defined.
6. Handshakes:
   - out_ready held low 5 cycles in DONE: out_result stable and in_ready=0; accepted on the first out_ready cycle.
   - rst_n low during SHIFT: next cycle IDLE, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/normalizare_rezultat.sv
// rtl/normalizare_rezultat.sv - post-add normalize, round-to-nearest-even and pack
// Optional NORMALIZARE_FTZ_EN flushes subnormal results to +0.
module normalizare_rezultat #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [FRAC_W+2:0]         in_mant,
    input  logic                      in_sticky,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_result,
    output logic                      out_ovf,
    output logic                      out_zero,
    output logic                      out_inexact
);
    localparam int M = FRAC_W + 3;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ROUND, DONE} state_t;
    state_t st;

    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic [M-1:0]     mant_q;
    logic             sticky_q;

    logic [EXP_W-1:0] exp_inc;
    logic [EXP_W-1:0] exp_dec;
    logic             rnd_inc;
    logic [FRAC_W+1:0] rnd_sum;
    logic [EXP_W-1:0] r_exp;
    logic [FRAC_W-1:0] r_frac;
    logic             r_ovf;
    logic             r_zero;

    assign exp_inc = exp_q + 1'b1;
    assign exp_dec = exp_q - 1'b1;
    assign rnd_inc = mant_q[0] & (sticky_q | mant_q[1]);
    assign rnd_sum = {1'b0, mant_q[M-2:1]} + {{(FRAC_W+1){1'b0}}, rnd_inc};

    always_comb begin
        r_exp  = exp_q;
        r_frac = rnd_sum[FRAC_W-1:0];
        r_ovf  = 1'b0;
        if (rnd_sum[FRAC_W+1]) begin
            r_frac = '0;
            r_exp  = exp_inc;
            r_ovf  = (exp_inc == EXP_ONES);
        end else if (exp_q == '0 && rnd_sum[FRAC_W]) begin
            r_exp = EXP_ONE;
        end
        r_zero = (r_exp == '0) && (r_frac == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_zero    <= 1'b0;
            out_inexact <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            sticky_q    <= 1'b0;
        end else begin
            case (st)
                IDLE: if (in_valid && in_ready) begin
                    sign_q      <= in_sign;
                    exp_q       <= in_exp;
                    mant_q      <= in_mant;
                    sticky_q    <= in_sticky;
                    out_ovf     <= 1'b0;
                    out_zero    <= 1'b0;
                    out_inexact <= 1'b0;
                    in_ready    <= 1'b0;
                    st          <= CHECK;
                end
                CHECK: begin
                    if (mant_q == '0) begin
                        out_result <= '0;
                        out_zero   <= 1'b1;
                        st         <= DONE;
                    end else if (mant_q[M-1]) begin
                        mant_q   <= {1'b0, mant_q[M-1:1]};
                        sticky_q <= sticky_q | mant_q[0];
                        if (exp_inc == EXP_ONES) begin
                            out_result <= {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
                            out_ovf    <= 1'b1;
                            st         <= DONE;
                        end else begin
                            exp_q <= exp_inc;
                            st    <= ROUND;
                        end
                    end else if (mant_q[M-2] || exp_q == '0) begin
                        st <= ROUND;
                    end else if (exp_q == EXP_ONE) begin
                        // exp 1 with no hidden bit already has subnormal scaling
                        exp_q <= '0;
                        st    <= ROUND;
                    end else begin
                        st <= SHIFT;
                    end
                end
                SHIFT: begin
                    mant_q <= {mant_q[M-2:0], 1'b0};
                    if (mant_q[M-3]) begin
                        exp_q <= exp_dec;
                        st    <= ROUND;
                    end else if (exp_dec == EXP_ONE) begin
                        exp_q <= '0;
                        st    <= ROUND;
                    end else begin
                        exp_q <= exp_dec;
                    end
                end
                ROUND: begin
                    out_inexact <= mant_q[0] | sticky_q;
`ifdef NORMALIZARE_FTZ_EN
                    if (r_exp == '0 && r_frac != '0) begin
                        out_result  <= '0;
                        out_zero    <= 1'b1;
                        out_inexact <= 1'b1;
                    end else begin
                        out_result <= {sign_q & ~r_zero, r_exp, r_frac};
                        out_ovf    <= r_ovf;
                        out_zero   <= r_zero;
                    end
`else
                    out_result <= {sign_q & ~r_zero, r_exp, r_frac};
                    out_ovf    <= r_ovf;
                    out_zero   <= r_zero;
`endif
                    st <= DONE;
                end
                DONE: begin
                    // valid rises one cycle after entry so the result is settled
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        st        <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
